// File: rtl/hazard_scoreboard.sv
// Hazard unit beside decode: shift-register scoreboard of in-flight writes,
// RAW/load-use/control/memory hazard detection and execute-stage bypass selects.
module hazard_scoreboard #(
  parameter  int REG_AW   = 5,
  parameter  int DEPTH    = 3,
  parameter  int FWD_EN   = 1,
  parameter  int LOAD_LAT = 1,
  parameter  int FLUSH    = 2,
  parameter  int PERF_W   = 32,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_use,
  input  logic              i_id_rs2_use,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_rd_we,
  input  logic              i_id_is_load,
  input  logic              i_jump_taken,
  input  logic              i_imem_ready,
  input  logic              i_dmem_ready,
  input  logic              i_dmem_use,
  output logic              o_data_hazard,
  output logic              o_control_hazard,
  output logic              o_stall,
  output logic              o_imem_stall,
  output logic              o_dmem_stall,
  output logic [SEL_W-1:0]  o_fwd_sel_rs1,
  output logic [SEL_W-1:0]  o_fwd_sel_rs2,
  output logic [PERF_W-1:0] o_hazard_cycles
);

  localparam int CNT_W = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  logic [DEPTH:1]             r_valid;
  logic [DEPTH:1]             r_load;
  logic [DEPTH:1][REG_AW-1:0] r_rd;
  logic [CNT_W-1:0]           r_flush_cnt;
  logic [PERF_W-1:0]          r_hazard_cycles;

  logic [DEPTH:1]   w_match1;
  logic [DEPTH:1]   w_match2;
  logic             w_found1;
  logic             w_found2;
  logic [SEL_W-1:0] w_y1;
  logic [SEL_W-1:0] w_y2;
  logic             w_lu1;
  logic             w_lu2;
  logic             w_raw;
  logic             w_ctrl;
  logic             w_imem_stall;
  logic             w_dmem_stall;
  logic             w_stall;
  logic             w_data_hazard;
  logic             w_new_valid;

  // Youngest matching stage per source; load-use is judged on that stage only.
  always_comb begin
    w_match1 = '0;
    w_match2 = '0;
    w_found1 = 1'b0;
    w_found2 = 1'b0;
    w_y1     = '0;
    w_y2     = '0;
    w_lu1    = 1'b0;
    w_lu2    = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_match1[k] = i_id_rs1_use & r_valid[k] & (r_rd[k] == i_id_rs1);
      w_match2[k] = i_id_rs2_use & r_valid[k] & (r_rd[k] == i_id_rs2);
      if (w_match1[k] && !w_found1) begin
        w_found1 = 1'b1;
        w_y1     = SEL_W'(k);
        w_lu1    = (k <= LOAD_LAT) && r_load[k];
      end
      if (w_match2[k] && !w_found2) begin
        w_found2 = 1'b1;
        w_y2     = SEL_W'(k);
        w_lu2    = (k <= LOAD_LAT) && r_load[k];
      end
    end
  end

  always_comb begin
    if (FWD_EN != 0) begin
      w_raw         = w_lu1 | w_lu2;
      o_fwd_sel_rs1 = (w_found1 && !w_lu1) ? w_y1 : '0;
      o_fwd_sel_rs2 = (w_found2 && !w_lu2) ? w_y2 : '0;
    end else begin
      w_raw         = (|w_match1) | (|w_match2);
      o_fwd_sel_rs1 = '0;
      o_fwd_sel_rs2 = '0;
    end
  end

  assign w_ctrl        = i_jump_taken | (r_flush_cnt != '0);
  assign w_imem_stall  = ~i_imem_ready;
  assign w_dmem_stall  = ~i_dmem_ready & i_dmem_use;
  assign w_stall       = w_dmem_stall | (w_imem_stall & i_jump_taken & ~i_dmem_use);
  // Control wins over data: a squashed instruction never requests a bubble.
  assign w_data_hazard = i_id_valid & w_raw & ~w_ctrl;
  assign w_new_valid   = i_id_valid & i_id_rd_we & (i_id_rd != '0) & ~w_data_hazard & ~w_ctrl;

  assign o_data_hazard    = w_data_hazard;
  assign o_control_hazard = w_ctrl;
  assign o_stall          = w_stall;
  assign o_imem_stall     = w_imem_stall;
  assign o_dmem_stall     = w_dmem_stall;
  assign o_hazard_cycles  = r_hazard_cycles;

  // A stall freezes the scoreboard and flush count; the perf counter keeps running.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid         <= '0;
      r_load          <= '0;
      r_rd            <= '0;
      r_flush_cnt     <= '0;
      r_hazard_cycles <= '0;
    end else begin
      if ((w_data_hazard || w_stall) && (r_hazard_cycles != {PERF_W{1'b1}}))
        r_hazard_cycles <= r_hazard_cycles + PERF_W'(1);
      if (!w_stall) begin
        for (int k = DEPTH; k >= 2; k--) begin
          r_valid[k] <= r_valid[k-1];
          r_load[k]  <= r_load[k-1];
          r_rd[k]    <= r_rd[k-1];
        end
        r_valid[1] <= w_new_valid;
        r_load[1]  <= i_id_is_load;
        r_rd[1]    <= i_id_rd;
        if (i_jump_taken)
          r_flush_cnt <= CNT_W'(FLUSH - 1);
        else if (r_flush_cnt != '0)
          r_flush_cnt <= r_flush_cnt - CNT_W'(1);
      end
    end
  end

endmodule
